noc_vc_packet_arbiter: RTL and testbench
========================================

// Module: noc_vc_packet_arbiter
// PURPOSE
//  Packet-level VC arbiter that drives the one-hot vc_grant of the VC merge stage.
//  - Picks one eligible virtual channel round-robin.
//  - Holds the grant until that channel's tail flit is accepted, so packets never interleave in the merge FIFO.
//  - Sits directly upstream of the VC merge; its grant also gates the per-channel valid/ready in the merge.
// PARAMETERS
//  CHANNELS  Noc_VC_Channel  number of virtual channels (>=2)
// PORTS
//  noc_clk      in   1         clock
//  noc_rst_n    in   1         reset, asynchronous, active-low
//  i_valid      in   CHANNELS  per-VC flit valid from the VC input buffers
//  i_tail       in   CHANNELS  per-VC: current flit is the packet tail (single-flit packet: head=tail)
//  i_vc_ready   in   CHANNELS  per-VC space available downstream (merge FIFO vc_ready)
//  i_ready      in   1         merge FIFO accepts the granted flit this cycle
//  o_vc_grant   out  CHANNELS  registered one-hot grant (all-zero = none)
//  o_locked     out  1         grant held mid-packet (state LOCKED)
//  o_grant_id   out  $clog2(CHANNELS)  index of the granted VC (0 when no grant)
// BEHAVIOUR
//  Definitions
//  - eligible[i] = i_valid[i] & i_vc_ready[i].
//  - fire = |(o_vc_grant & i_valid) & i_ready.
//  - tail_fire = fire & i_tail[o_grant_id].
//  Reset
//  - o_vc_grant=0, o_locked=0, o_grant_id=0, rr_ptr=0, state IDLE.
//  - Reset asserted mid-packet drops the grant immediately; no flit is considered accepted in that cycle.
//  FSM (arb_state_e: IDLE, LOCKED)
//  - IDLE, no eligible VC: stay IDLE, grant stays 0.
//  - IDLE, any eligible VC: winner = first eligible at or after rr_ptr, cyclically.
//    Next cycle: o_vc_grant = onehot(winner), state LOCKED. Latency request->grant = 1 cycle.
//  - LOCKED: grant is stable regardless of i_valid/i_vc_ready changes.
//    Stalls (i_ready=0 or i_valid=0) hold the grant indefinitely. No timeout.
//  - LOCKED, fire without tail: no change.
//  - LOCKED, tail_fire:
//    - rr_ptr <= (grant_id+1) mod CHANNELS.
//    - Same cycle, re-arbitrate from the new rr_ptr over eligible, excluding the current VC's just-consumed tail.
//    - If a winner exists: next-cycle grant = winner, stay LOCKED (back-to-back, zero bubbles).
//    - Else: grant -> 0, state IDLE.
//  - The granted VC only regains priority after all other eligible VCs have been served (no starvation).
//  - o_locked = (state==LOCKED). o_grant_id is the encoded o_vc_grant.
//  Invariants
//  - o_vc_grant is always 0 or one-hot ($onehot0).
//  - rr_ptr wraps CHANNELS-1 -> 0.
//  - Never grant a VC with i_vc_ready=0 at arbitration time.
//  - Simultaneous requests on all VCs with rr_ptr=k: VC k wins.
// STRUCTURE
//  Noc_parameters package
//  - Noc_VC_Channel (already present).
//  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e.
//  - localparam Noc_VC_Id_Width = $clog2(Noc_VC_Channel).
//  Sub-module noc_rr_pick
//  - Combinational, parameter N.
//  - Inputs: req[N], ptr. Outputs: onehot grant[N], any.
//  - Implemented as a double-width masked priority encoder.
//  Top level
//  - FSM, rr_ptr register, grant register, grant encoder.
// TESTING
//  1 Reset, then CH0 single-flit packet: i_valid=4'b0001, i_tail=1, i_vc_ready=F, i_ready=1 -> grant 0001 at cycle 1; IDLE at cycle 2; rr_ptr=1.
//  2 All VCs request 3-flit packets, i_ready=1 -> grant order 0001,0010,0100,1000,0001, each held exactly 3 fires, no idle cycle between packets.
//  3 Lock under stall: CH2 granted, i_ready=0 for 10 cycles while CH0/CH1 assert valid -> grant stays 0100; on tail fire, CH3 or the next eligible VC is granted.
//  4 Credit gating: i_valid=0011, i_vc_ready=0010, rr_ptr=0 -> CH1 granted, CH0 never granted until i_vc_ready[0]=1.
//  5 Async reset mid-packet: assert noc_rst_n=0 between clock edges while CH1 locked -> o_vc_grant=0 and o_locked=0 immediately; after release, arbitration restarts at CH0.
//  6 Assertions throughout: $onehot0(o_vc_grant); grant never changes in LOCKED without tail_fire; no VC waits more than CHANNELS-1 packets.

Source files
------------

// File: rtl/noc_vc_packet_arbiter_pkg.sv
// Shared NoC virtual-channel parameters and the packet arbiter state type.
package noc_vc_packet_arbiter_pkg;

    localparam int Noc_VC_Channel  = 4;
    localparam int Noc_VC_Id_Width = $clog2(Noc_VC_Channel);

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

endpackage

// File: rtl/noc_vc_packet_arbiter_rr_pick.sv
// Round-robin pick: first set request at or after ptr, cyclically.
// The request vector is doubled so the wrap-around falls out of a plain lowest-bit isolate.
module noc_rr_pick
    import noc_vc_packet_arbiter_pkg::*;
#(
    parameter int N = Noc_VC_Channel,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             any
);

    localparam logic [2*N-1:0] ONE = (2*N)'(1);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;
    logic [2*N-1:0] lowest;

    always_comb begin
        dbl    = {req, req};
        // Low copy keeps positions >= ptr, high copy supplies the wrapped positions.
        masked = dbl & ~((ONE << ptr) - ONE);
        lowest = masked & (~masked + ONE);
        grant  = lowest[N-1:0] | lowest[2*N-1:N];
        any    = |req;
    end

endmodule

// File: rtl/noc_vc_packet_arbiter.sv
// Packet-level VC arbiter: round-robin over eligible channels, grant held from head
// to accepted tail so packets never interleave in the downstream merge FIFO.
module noc_vc_packet_arbiter
    import noc_vc_packet_arbiter_pkg::*;
#(
    parameter int CHANNELS = Noc_VC_Channel
) (
    input  logic                        noc_clk,
    input  logic                        noc_rst_n,
    input  logic [CHANNELS-1:0]         i_valid,
    input  logic [CHANNELS-1:0]         i_tail,
    input  logic [CHANNELS-1:0]         i_vc_ready,
    input  logic                        i_ready,
    output logic [CHANNELS-1:0]         o_vc_grant,
    output logic                        o_locked,
    output logic [$clog2(CHANNELS)-1:0] o_grant_id
);

    localparam int              ID_W    = $clog2(CHANNELS);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(CHANNELS - 1);

    arb_state_e          state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     next_ptr;
    logic [ID_W-1:0]     pick_ptr;
    logic [ID_W-1:0]     pick_id;
    logic [CHANNELS-1:0] eligible;
    logic [CHANNELS-1:0] pick_req;
    logic [CHANNELS-1:0] pick_grant;
    logic                pick_any;
    logic                fire;
    logic                tail_fire;

    function automatic logic [ID_W-1:0] encode(input logic [CHANNELS-1:0] onehot);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (onehot[i]) id = id | ID_W'(i);
        end
        return id;
    endfunction

    always_comb begin
        eligible  = i_valid & i_vc_ready;
        fire      = (|(o_vc_grant & i_valid)) & i_ready;
        tail_fire = fire & i_tail[o_grant_id];
        next_ptr  = (o_grant_id == LAST_ID) ? '0 : o_grant_id + ID_W'(1);
        // On a tail the just-served channel drops to lowest priority and is excluded outright.
        if (state == ARB_LOCKED) begin
            pick_ptr = next_ptr;
            pick_req = eligible & ~o_vc_grant;
        end else begin
            pick_ptr = rr_ptr;
            pick_req = eligible;
        end
        pick_id = encode(pick_grant);
    end

    noc_rr_pick #(
        .N (CHANNELS)
    ) u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .grant (pick_grant),
        .any   (pick_any)
    );

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state      <= ARB_IDLE;
            rr_ptr     <= '0;
            o_vc_grant <= '0;
            o_grant_id <= '0;
            o_locked   <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        state      <= ARB_LOCKED;
                        o_vc_grant <= pick_grant;
                        o_grant_id <= pick_id;
                        o_locked   <= 1'b1;
                    end
                end
                ARB_LOCKED: begin
                    if (tail_fire) begin
                        rr_ptr <= next_ptr;
                        if (pick_any) begin
                            o_vc_grant <= pick_grant;
                            o_grant_id <= pick_id;
                        end else begin
                            state      <= ARB_IDLE;
                            o_vc_grant <= '0;
                            o_grant_id <= '0;
                            o_locked   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= ARB_IDLE;
                    o_vc_grant <= '0;
                    o_grant_id <= '0;
                    o_locked   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_vc_packet_arbiter.sv
// Randomized and directed bench for noc_vc_packet_arbiter against a queue-free
// round-robin packet model (grant owner + pointer, cyclic scan).
module tb_noc_vc_packet_arbiter;

    localparam int N = 4;

    logic         noc_clk = 1'b0;
    logic         noc_rst_n = 1'b0;
    logic [N-1:0] i_valid = '0;
    logic [N-1:0] i_tail = '0;
    logic [N-1:0] i_vc_ready = '0;
    logic         i_ready = 1'b0;
    logic [N-1:0] o_vc_grant;
    logic         o_locked;
    logic [1:0]   o_grant_id;

    noc_vc_packet_arbiter #(.CHANNELS(N)) dut (
        .noc_clk    (noc_clk),
        .noc_rst_n  (noc_rst_n),
        .i_valid    (i_valid),
        .i_tail     (i_tail),
        .i_vc_ready (i_vc_ready),
        .i_ready    (i_ready),
        .o_vc_grant (o_vc_grant),
        .o_locked   (o_locked),
        .o_grant_id (o_grant_id)
    );

    always #5 noc_clk = ~noc_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owning VC (-1 = none) and round-robin pointer.
    int m_grant = -1;
    int m_ptr   = 0;
    int wait_pkts[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic int scan(input int from, input logic [N-1:0] el);
        for (int k = 0; k < N; k++) begin
            if (el[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_onehot();
        return (m_grant < 0) ? 32'd0 : (32'd1 << m_grant);
    endfunction

    task automatic model_reset();
        m_grant = -1;
        m_ptr   = 0;
        for (int i = 0; i < N; i++) wait_pkts[i] = 0;
    endtask

    // Apply one cycle of inputs, advance the model, check outputs after the edge.
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] t,
                         input logic [N-1:0] c, input logic r);
        logic [N-1:0] el;
        logic [N-1:0] el_arb;
        logic [N-1:0] pre_grant;
        logic         pre_locked;
        logic         pre_tail;
        i_valid    = v;
        i_tail     = t;
        i_vc_ready = c;
        i_ready    = r;
        pre_grant  = o_vc_grant;
        pre_locked = o_locked;
        pre_tail   = ((pre_grant & v) != 0) && r && ((pre_grant & t) != 0);
        el         = v & c;
        el_arb     = el;
        if (m_grant < 0) begin
            m_grant = scan(m_ptr, el_arb);
        end else if (v[m_grant] && r && t[m_grant]) begin
            m_ptr           = (m_grant + 1) % N;
            el_arb[m_grant] = 1'b0;
            m_grant         = scan(m_ptr, el_arb);
        end
        @(posedge noc_clk);
        #1;
        chk("grant", 32'(o_vc_grant), exp_onehot());
        chk("locked", 32'(o_locked), (m_grant >= 0) ? 32'd1 : 32'd0);
        chk("grant_id", 32'(o_grant_id), (m_grant < 0) ? 32'd0 : 32'(m_grant));
        chk("onehot0", 32'($onehot0(o_vc_grant)), 32'd1);
        if (pre_locked && !pre_tail) chk("lock_hold", 32'(o_vc_grant), 32'(pre_grant));
        if (o_vc_grant != pre_grant && o_vc_grant != '0)
            chk("grant_eligible", 32'((o_vc_grant & ~el) == '0), 32'd1);
        for (int i = 0; i < N; i++) begin
            if (o_vc_grant[i] || pre_grant[i] || !el[i]) begin
                wait_pkts[i] = 0;
            end else if (pre_tail) begin
                wait_pkts[i]++;
                chk("no_starve", 32'(wait_pkts[i] <= N - 1), 32'd1);
            end
        end
    endtask

    task automatic do_reset();
        noc_rst_n  = 1'b0;
        i_valid    = '0;
        i_tail     = '0;
        i_vc_ready = '0;
        i_ready    = 1'b0;
        repeat (2) @(posedge noc_clk);
        #1;
        chk("rst_grant", 32'(o_vc_grant), 32'd0);
        chk("rst_locked", 32'(o_locked), 32'd0);
        chk("rst_id", 32'(o_grant_id), 32'd0);
        model_reset();
        @(negedge noc_clk);
        noc_rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int           cnt[N];
        logic [N-1:0] t;
        logic [N-1:0] g_before;
        logic         seen;

        // Single-flit packet on CH0, then pointer should have moved to CH1.
        do_reset();
        cycle(4'b0001, 4'b0001, 4'hF, 1'b1);
        chk("t1_grant", 32'(o_vc_grant), 32'h1);
        cycle(4'b0001, 4'b0001, 4'hF, 1'b1);
        chk("t1_idle", 32'(o_locked), 32'd0);
        cycle(4'b1111, 4'b0000, 4'hF, 1'b0);
        chk("t1_ptr", 32'(o_vc_grant), 32'h2);

        // Back-to-back 3-flit packets on every VC.
        do_reset();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int k = 1; k <= 15; k++) begin
            for (int i = 0; i < N; i++) t[i] = (cnt[i] == 2);
            g_before = o_vc_grant;
            cycle(4'b1111, t, 4'hF, 1'b1);
            for (int i = 0; i < N; i++) if (g_before[i]) cnt[i] = (cnt[i] + 1) % 3;
            chk("t2_order", 32'(o_vc_grant), 32'd1 << (((k - 1) / 3) % 4));
        end

        // Lock held through a long stall, then hand-off after the tail.
        do_reset();
        cycle(4'b0100, 4'b0000, 4'hF, 1'b1);
        chk("t3_grant", 32'(o_vc_grant), 32'h4);
        for (int k = 0; k < 10; k++) begin
            cycle(4'b0111, 4'b0000, 4'hF, 1'b0);
            chk("t3_hold", 32'(o_vc_grant), 32'h4);
        end
        cycle(4'b0111, 4'b0100, 4'hF, 1'b1);
        chk("t3_next", 32'(o_vc_grant), 32'h1);

        // Credit gating keeps CH0 out until its vc_ready returns.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cycle(4'b0011, 4'b0011, 4'b0010, 1'b1);
            chk("t4_no_ch0", 32'(o_vc_grant[0]), 32'd0);
        end
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle(4'b0011, 4'b0011, 4'b0011, 1'b1);
            if (o_vc_grant[0]) seen = 1'b1;
        end
        chk("t4_ch0", 32'(seen), 32'd1);

        // Asynchronous reset between edges while CH1 is mid-packet.
        do_reset();
        cycle(4'b0010, 4'b0000, 4'hF, 1'b0);
        chk("t5_locked", 32'(o_vc_grant), 32'h2);
        #2;
        noc_rst_n = 1'b0;
        #1;
        chk("t5_async_grant", 32'(o_vc_grant), 32'd0);
        chk("t5_async_locked", 32'(o_locked), 32'd0);
        model_reset();
        @(negedge noc_clk);
        noc_rst_n = 1'b1;
        cycle(4'b1111, 4'b0000, 4'hF, 1'b0);
        chk("t5_restart", 32'(o_vc_grant), 32'h1);

        // Randomized traffic.
        do_reset();
        for (int k = 0; k < 500; k++) begin
            cycle(N'($urandom), N'($urandom), N'($urandom | $urandom),
                  ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
